jt12_modmix: RTL and testbench

Parametrised operator-modulation engine for the FM core: sequences the 4×NUM_CH operator slots, keeps a per-channel store of previous operator outputs and S1 feedback history, and produces each slot's phase-modulation input. Each channel has its own algorithm and feedback level, with shadowed configuration. Sits between the register front-end and the operator/phase pipeline, and replaces hard-wired prev/prevprev delay taps.

---
 rtl/jt12_mod_pkg.sv | 23 ++
 rtl/jt12_modmix_store.sv | 53 +++++
 rtl/jt12_modmix.sv | 121 ++++++++++++
 tb/tb_jt12_modmix.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/jt12_mod_pkg.sv
// jt12_mod_pkg: slot encoding, group order and modulation source selection
package jt12_mod_pkg;
    typedef enum logic [1:0] {S1 = 2'd0, S2 = 2'd1, S3 = 2'd2, S4 = 2'd3} slot_t;

    function automatic slot_t next_grp(input slot_t s);
        return s == S1 ? S3 : s == S3 ? S2 : s == S2 ? S4 : S1;
    endfunction

    // {s1_p, s2, s3} sources summed into a non-S1 slot's modulation
    function automatic logic [2:0] src_mask(input logic [2:0] alg, input slot_t slot);
        logic [2:0] m;
        m = 3'b000;
        case (slot)
            S2: m = (alg inside {3'd0, 3'd3, 3'd4, 3'd5, 3'd6}) ? 3'b100 : 3'b000;
            S3: m = (alg inside {3'd0, 3'd2}) ? 3'b010 : alg == 3'd1 ? 3'b110 :
                    alg == 3'd5 ? 3'b100 : 3'b000;
            S4: m = (alg inside {3'd0, 3'd1, 3'd4}) ? 3'b001 : alg == 3'd2 ? 3'b101 :
                    alg == 3'd3 ? 3'b011 : alg == 3'd5 ? 3'b100 : 3'b000;
            default: m = 3'b000;
        endcase
        return m;
    endfunction
endpackage

// File: rtl/jt12_modmix_store.sv
// jt12_modmix_store: per-channel operator history with S1 shift and write bypass
module jt12_modmix_store
    import jt12_mod_pkg::*;
#(
    parameter int NUM_CH = 6,
    parameter int OPW    = 14
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [2:0]            wr_ch,
    input  slot_t                 wr_slot,
    input  logic signed [OPW-1:0] din,
    input  logic [2:0]            rd_ch,
    output logic signed [OPW-1:0] s1_p,
    output logic signed [OPW-1:0] s1_pp,
    output logic signed [OPW-1:0] s2,
    output logic signed [OPW-1:0] s3
);
    localparam logic [3:0] NCH = 4'(NUM_CH);
    logic signed [OPW-1:0] s1_p_r [NUM_CH];
    logic signed [OPW-1:0] s1_pp_r [NUM_CH];
    logic signed [OPW-1:0] s2_r [NUM_CH];
    logic signed [OPW-1:0] s3_r [NUM_CH];
    logic wr_ok, hit;
    assign wr_ok = we && ({1'b0, wr_ch} < NCH);
    assign hit   = wr_ok && wr_ch == rd_ch;
    // S1 writes push the previous S1 down; S4 results are never needed
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                s1_p_r[i]  <= '0;
                s1_pp_r[i] <= '0;
                s2_r[i]    <= '0;
                s3_r[i]    <= '0;
            end
        end else if (wr_ok) begin
            case (wr_slot)
                S1: begin
                    s1_pp_r[wr_ch] <= s1_p_r[wr_ch];
                    s1_p_r[wr_ch]  <= din;
                end
                S2: s2_r[wr_ch] <= din;
                S3: s3_r[wr_ch] <= din;
                default: ;
            endcase
        end
    end
    assign s1_p  = hit && wr_slot == S1 ? din : s1_p_r[rd_ch];
    assign s1_pp = hit && wr_slot == S1 ? s1_p_r[rd_ch] : s1_pp_r[rd_ch];
    assign s2    = hit && wr_slot == S2 ? din : s2_r[rd_ch];
    assign s3    = hit && wr_slot == S3 ? din : s3_r[rd_ch];
endmodule

// File: rtl/jt12_modmix.sv
// jt12_modmix: operator slot sequencer producing per-slot phase modulation
module jt12_modmix
    import jt12_mod_pkg::*;
#(
    parameter int NUM_CH = 6,
    parameter int OPW    = 14
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clk_en,
    input  logic                cfg_we,
    input  logic [2:0]          cfg_ch,
    input  logic [2:0]          cfg_alg,
    input  logic [2:0]          cfg_fb,
    input  logic                op_we,
    input  logic [2:0]          op_ch,
    input  logic [1:0]          op_slot,
    input  logic signed [OPW-1:0] op_din,
    output logic [2:0]          cur_ch,
    output logic                s1_enters,
    output logic                s2_enters,
    output logic                s3_enters,
    output logic                s4_enters,
    output logic                zero,
    output logic signed [OPW:0] mod_out
);
    localparam logic [3:0] NCH  = 4'(NUM_CH);
    localparam logic [2:0] LAST = 3'(NUM_CH - 1);
    slot_t slot;
    logic [2:0] ch;
    logic [2:0] sh_alg [NUM_CH];
    logic [2:0] sh_fb [NUM_CH];
    logic [2:0] act_alg [NUM_CH];
    logic [2:0] act_fb [NUM_CH];
    logic signed [OPW-1:0] s1_p, s1_pp, s2, s3;
    logic cfg_ok, cfg_hit;
    logic [2:0] alg_now, fb_now, mask;
    logic [3:0] shamt;
    logic signed [OPW:0] a, b, c, fb_sum, fb_val, mix;

    jt12_modmix_store #(.NUM_CH(NUM_CH), .OPW(OPW)) u_store (
        .clk     (clk),
        .rst     (rst),
        .we      (op_we),
        .wr_ch   (op_ch),
        .wr_slot (slot_t'(op_slot)),
        .din     (op_din),
        .rd_ch   (ch),
        .s1_p    (s1_p),
        .s1_pp   (s1_pp),
        .s2      (s2),
        .s3      (s3)
    );

    // the S1 slot latches the shadow, so a same-cycle config write must win there
    assign cfg_ok  = cfg_we && ({1'b0, cfg_ch} < NCH);
    assign cfg_hit = cfg_ok && cfg_ch == ch;
    assign alg_now = slot == S1 ? (cfg_hit ? cfg_alg : sh_alg[ch]) : act_alg[ch];
    assign fb_now  = slot == S1 ? (cfg_hit ? cfg_fb : sh_fb[ch]) : act_fb[ch];
    assign mask    = src_mask(alg_now, slot);
    assign a       = mask[2] ? {s1_p[OPW-1], s1_p} : '0;
    assign b       = mask[1] ? {s2[OPW-1], s2} : '0;
    assign c       = mask[0] ? {s3[OPW-1], s3} : '0;
    assign fb_sum  = {s1_p[OPW-1], s1_p} + {s1_pp[OPW-1], s1_pp};
    assign shamt   = 4'd9 - {1'b0, fb_now};
    assign fb_val  = fb_sum >>> shamt;
    assign mix     = slot == S1 ? (fb_now == 3'd0 ? '0 : fb_val) : a + b + c;

    // channel-major within a group, groups in S1, S3, S2, S4 order
    always_ff @(posedge clk) begin
        if (rst) begin
            slot <= S1;
            ch   <= '0;
        end else if (clk_en) begin
            ch   <= ch == LAST ? 3'd0 : ch + 3'd1;
            slot <= ch == LAST ? next_grp(slot) : slot;
        end
    end

    // shadow takes writes anytime; active is refreshed as the channel's S1 issues
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                sh_alg[i]  <= '0;
                sh_fb[i]   <= '0;
                act_alg[i] <= '0;
                act_fb[i]  <= '0;
            end
        end else begin
            if (cfg_ok) begin
                sh_alg[cfg_ch] <= cfg_alg;
                sh_fb[cfg_ch]  <= cfg_fb;
            end
            if (clk_en && slot == S1) begin
                act_alg[ch] <= alg_now;
                act_fb[ch]  <= fb_now;
            end
        end
    end

    // issued slot outputs, held until the next strobe
    always_ff @(posedge clk) begin
        if (rst) begin
            cur_ch    <= '0;
            s1_enters <= 1'b0;
            s2_enters <= 1'b0;
            s3_enters <= 1'b0;
            s4_enters <= 1'b0;
            zero      <= 1'b0;
            mod_out   <= '0;
        end else if (clk_en) begin
            cur_ch    <= ch;
            s1_enters <= slot == S1;
            s2_enters <= slot == S2;
            s3_enters <= slot == S3;
            s4_enters <= slot == S4;
            zero      <= slot == S1 && ch == 3'd0;
            mod_out   <= mix;
        end
    end
endmodule

// File: tb/tb_jt12_modmix.sv
// tb_jt12_modmix: directed and random checks against a behavioural slot model
module tb_jt12_modmix;
    localparam int NUM_CH = 6;
    localparam int OPW    = 14;

    logic clk = 1'b0;
    logic rst, clk_en, cfg_we, op_we;
    logic [2:0] cfg_ch, cfg_alg, cfg_fb, op_ch;
    logic [1:0] op_slot;
    logic signed [OPW-1:0] op_din;
    logic [2:0] cur_ch;
    logic s1_enters, s2_enters, s3_enters, s4_enters, zero;
    logic signed [OPW:0] mod_out;

    int m_p [NUM_CH], m_pp [NUM_CH], m_s2 [NUM_CH], m_s3 [NUM_CH];
    int sh_alg [NUM_CH], sh_fb [NUM_CH], ac_alg [NUM_CH], ac_fb [NUM_CH];
    int pos, e_ch, e_en, e_zero, e_mod;
    int passed = 0, total = 0;

    jt12_modmix #(.NUM_CH(NUM_CH), .OPW(OPW)) dut (
        .clk       (clk),
        .rst       (rst),
        .clk_en    (clk_en),
        .cfg_we    (cfg_we),
        .cfg_ch    (cfg_ch),
        .cfg_alg   (cfg_alg),
        .cfg_fb    (cfg_fb),
        .op_we     (op_we),
        .op_ch     (op_ch),
        .op_slot   (op_slot),
        .op_din    (op_din),
        .cur_ch    (cur_ch),
        .s1_enters (s1_enters),
        .s2_enters (s2_enters),
        .s3_enters (s3_enters),
        .s4_enters (s4_enters),
        .zero      (zero),
        .mod_out   (mod_out)
    );

    always #5 clk = ~clk;

    // sn: 1..4 for S1..S4
    function automatic int ref_mod(int sn, int alg, int fb, int p, int pp, int s2, int s3);
        case (sn)
            1: return fb == 0 ? 0 : (p + pp) >>> (9 - fb);
            2: return (alg == 0 || alg == 3 || alg == 4 || alg == 5 || alg == 6) ? p : 0;
            3: return (alg == 0 || alg == 2) ? s2 : alg == 1 ? p + s2 : alg == 5 ? p : 0;
            default: return (alg == 0 || alg == 1 || alg == 4) ? s3 : alg == 2 ? s3 + p :
                            alg == 3 ? s3 + s2 : alg == 5 ? p : 0;
        endcase
    endfunction

    task automatic chk(string tag, int got, int exp);
        total++;
        assert (got === exp) passed++;
        else $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic tick();
        int c, g, sn;
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                m_p[i] = 0; m_pp[i] = 0; m_s2[i] = 0; m_s3[i] = 0;
                sh_alg[i] = 0; sh_fb[i] = 0; ac_alg[i] = 0; ac_fb[i] = 0;
            end
            pos = 0; e_ch = 0; e_en = 0; e_zero = 0; e_mod = 0;
        end else begin
            if (op_we && int'(op_ch) < NUM_CH) begin
                c = int'(op_ch);
                if (op_slot == 2'd0) begin m_pp[c] = m_p[c]; m_p[c] = int'(op_din); end
                else if (op_slot == 2'd1) m_s2[c] = int'(op_din);
                else if (op_slot == 2'd2) m_s3[c] = int'(op_din);
            end
            if (cfg_we && int'(cfg_ch) < NUM_CH) begin
                sh_alg[cfg_ch] = int'(cfg_alg);
                sh_fb[cfg_ch]  = int'(cfg_fb);
            end
            if (clk_en) begin
                c  = pos % NUM_CH;
                g  = pos / NUM_CH;
                sn = g == 0 ? 1 : g == 1 ? 3 : g == 2 ? 2 : 4;
                if (sn == 1) begin ac_alg[c] = sh_alg[c]; ac_fb[c] = sh_fb[c]; end
                e_ch   = c;
                e_en   = 1 << (4 - sn);
                e_zero = pos == 0 ? 1 : 0;
                e_mod  = ref_mod(sn, ac_alg[c], ac_fb[c], m_p[c], m_pp[c], m_s2[c], m_s3[c]);
                pos    = (pos + 1) % (4 * NUM_CH);
            end
        end
        @(posedge clk);
        #1;
        chk("cur_ch", int'(cur_ch), e_ch);
        chk("enters", int'({s1_enters, s2_enters, s3_enters, s4_enters}), e_en);
        chk("zero", int'(zero), e_zero);
        chk("mod_out", int'(mod_out), e_mod);
        rst = 0; clk_en = 0; op_we = 0; cfg_we = 0;
    endtask

    task automatic issue(int n);
        repeat (n) begin clk_en = 1; tick(); end
    endtask

    task automatic opw(int c, int s, int d, bit en);
        op_we = 1; op_ch = 3'(c); op_slot = 2'(s); op_din = OPW'(d); clk_en = en;
        tick();
    endtask

    task automatic cfgw(int c, int alg, int fb);
        cfg_we = 1; cfg_ch = 3'(c); cfg_alg = 3'(alg); cfg_fb = 3'(fb);
        tick();
    endtask

    initial begin
        rst = 1; clk_en = 0; cfg_we = 0; op_we = 0;
        cfg_ch = 0; cfg_alg = 0; cfg_fb = 0; op_ch = 0; op_slot = 0; op_din = 0;
        #2;
        tick();
        chk("rst_zero", int'(zero), 0);
        chk("rst_mod", int'(mod_out), 0);
        issue(1);
        chk("first_zero", int'(zero), 1);
        issue(23);
        chk("last_s4", int'({s4_enters, cur_ch}), 8 + NUM_CH - 1);
        issue(1);
        chk("wrap_zero", int'(zero), 1);
        rst = 1; tick();

        cfgw(2, 0, 0);
        opw(2, 0, 100, 0);
        opw(2, 1, -50, 0);
        issue(9);
        chk("s3_ch2", int'(mod_out), -50);
        issue(6);
        chk("s2_ch2", int'(mod_out), 100);
        issue(9);

        cfgw(1, 2, 0);
        opw(1, 0, 1000, 0);
        opw(1, 2, 2000, 0);
        issue(20);
        chk("s4_alg2", int'(mod_out), 3000);
        issue(4);
        opw(1, 0, 8191, 0);
        opw(1, 2, 8191, 0);
        issue(20);
        chk("s4_nowrap", int'(mod_out), 16382);
        issue(4);

        cfgw(0, 0, 7);
        opw(0, 0, 512, 0);
        opw(0, 0, 512, 0);
        issue(1);
        chk("fb7", int'(mod_out), 256);
        issue(23);
        cfgw(0, 0, 0);
        issue(1);
        chk("fb0", int'(mod_out), 0);
        issue(23);

        opw(3, 0, 300, 0);
        opw(3, 1, 40, 0);
        opw(3, 2, 5, 0);
        issue(4);
        cfgw(3, 7, 0);
        issue(6);
        chk("shadow_s3", int'(mod_out), 40);
        issue(6);
        chk("shadow_s2", int'(mod_out), 300);
        issue(6);
        chk("shadow_s4", int'(mod_out), 5);
        issue(2);
        issue(10);
        chk("alg7_s3", int'(mod_out), 0);
        issue(14);

        issue(10);
        opw(4, 1, 77, 1);
        chk("bypass", int'(mod_out), 77);
        issue(13);

        for (int i = 0; i < 400; i++) begin
            rst     = $urandom_range(63) == 0;
            clk_en  = 1'($urandom_range(1));
            op_we   = 1'($urandom_range(1));
            op_ch   = 3'($urandom_range(7));
            op_slot = 2'($urandom_range(3));
            op_din  = OPW'($urandom);
            cfg_we  = $urandom_range(3) == 0;
            cfg_ch  = 3'($urandom_range(7));
            cfg_alg = 3'($urandom_range(7));
            cfg_fb  = 3'($urandom_range(7));
            tick();
        end

        issue(7);
        rst = 1; clk_en = 1; op_we = 1; op_ch = 0; op_slot = 0; op_din = 1234;
        tick();
        chk("midrst_mod", int'(mod_out), 0);
        chk("midrst_en", int'({s1_enters, s2_enters, s3_enters, s4_enters}), 0);
        issue(1);
        chk("restart_zero", int'(zero), 1);
        chk("restart_ch", int'(cur_ch), 0);
        chk("restart_s1", int'(s1_enters), 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
